// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the serial configuration loader.
// Holds the per-channel FSM state type and the default build constants
// used by cfg_ser_chan and cfg_serial_loader.
package cfg_loader_pkg;

  // Per-channel frame reception states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOCKED = 2'd3
  } chan_state_t;

  localparam int DEF_NCH     = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_PAR_EN  = 1;
  localparam int DEF_PAR_ODD = 0;

endpackage : cfg_loader_pkg

// File: rtl/cfg_ser_chan.sv
// One serial configuration channel.
// Waits for a start bit, shifts in a W-bit payload MSB first, optionally
// checks one parity bit, then latches the word and locks until re-armed.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-low reset
//   ser_i    - serial data line (idle low)
//   rearm_i  - single-cycle request to return to IDLE
//   cfg_o    - last successfully loaded word
//   done_o   - a valid, parity-checked word is held
//   perr_o   - last frame failed the parity check
module cfg_ser_chan
  import cfg_loader_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int PAR_EN  = DEF_PAR_EN,
  parameter int PAR_ODD = DEF_PAR_ODD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_i,
  input  logic         rearm_i,
  output logic [W-1:0] cfg_o,
  output logic         done_o,
  output logic         perr_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  chan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  cfg_q, cfg_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;

  logic [W-1:0]  shifted;
  logic          par_pass;

  assign shifted  = {work_q[W-2:0], ser_i};
  // XOR over payload and parity bit must match the selected parity sense.
  assign par_pass = ((^work_q) ^ ser_i) == (PAR_ODD != 0);

  // Next-state and next-output logic. Re-arm overrides everything the
  // current state would otherwise do, including a frame completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    cfg_d   = cfg_q;
    done_d  = done_q;
    perr_d  = perr_q;

    if (rearm_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      perr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ser_i) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          work_d = shifted;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            if (PAR_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = LOCKED;
              cfg_d   = shifted;
              done_d  = 1'b1;
              perr_d  = 1'b0;
            end
          end
        end
        PARITY: begin
          if (par_pass) begin
            state_d = LOCKED;
            cfg_d   = work_q;
            done_d  = 1'b1;
            perr_d  = 1'b0;
          end else begin
            // A failed frame leaves the old word in place and lets the
            // sender retry without needing a re-arm.
            state_d = IDLE;
            done_d  = 1'b0;
            perr_d  = 1'b1;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign cfg_o  = cfg_q;
  assign done_o = done_q;
  assign perr_o = perr_q;

endmodule : cfg_ser_chan

// File: rtl/cfg_serial_loader.sv
// Multi-channel serial configuration loader.
// Instantiates NCH independent cfg_ser_chan receivers and packs their words.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-low reset
//   ser_i      - serial data line per channel
//   rearm_i    - per-channel re-arm request
//   cfg_o      - packed words, channel c at [c*W +: W]
//   done_o     - per-channel word-valid flags
//   perr_o     - per-channel parity-error flags
//   all_done_o - every channel holds a valid word
module cfg_serial_loader
  import cfg_loader_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int W       = DEF_W,
  parameter int PAR_EN  = DEF_PAR_EN,
  parameter int PAR_ODD = DEF_PAR_ODD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ser_i,
  input  logic [NCH-1:0]   rearm_i,
  output logic [NCH*W-1:0] cfg_o,
  output logic [NCH-1:0]   done_o,
  output logic [NCH-1:0]   perr_o,
  output logic             all_done_o
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    cfg_ser_chan #(
      .W       (W),
      .PAR_EN  (PAR_EN),
      .PAR_ODD (PAR_ODD)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .ser_i   (ser_i[c]),
      .rearm_i (rearm_i[c]),
      .cfg_o   (cfg_o[c*W +: W]),
      .done_o  (done_o[c]),
      .perr_o  (perr_o[c])
    );
  end

  assign all_done_o = &done_o;

endmodule : cfg_serial_loader

// File: tb/tb_cfg_serial_loader.sv
// Self-checking bench for cfg_serial_loader.
// DUT A: NCH=4, W=8, even parity. DUT B: NCH=1, W=8, no parity bit.
// Drivers push expected snapshots into a queue; a monitor compares them
// on the falling edge following each push.
module tb_cfg_serial_loader;

  logic        clk;
  logic        rst;
  logic [3:0]  ser;
  logic [3:0]  rearm;
  logic [31:0] cfg;
  logic [3:0]  done;
  logic [3:0]  perr;
  logic        alld;

  logic [0:0]  ser_b;
  logic [0:0]  rearm_b;
  logic [7:0]  cfg_b;
  logic [0:0]  done_b;
  logic [0:0]  perr_b;
  logic        alld_b;

  cfg_serial_loader #(.NCH(4), .W(8), .PAR_EN(1), .PAR_ODD(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .ser_i      (ser),
    .rearm_i    (rearm),
    .cfg_o      (cfg),
    .done_o     (done),
    .perr_o     (perr),
    .all_done_o (alld)
  );

  cfg_serial_loader #(.NCH(1), .W(8), .PAR_EN(0), .PAR_ODD(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ser_i      (ser_b),
    .rearm_i    (rearm_b),
    .cfg_o      (cfg_b),
    .done_o     (done_b),
    .perr_o     (perr_b),
    .all_done_o (alld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] cfg;
    logic [3:0]  done;
    logic [3:0]  perr;
    logic        alld;
    logic [7:0]  cfg_b;
    logic        done_b;
    logic        perr_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Frame-level reference model: what each channel holds after each frame.
  logic [7:0] m_cfg[4];
  logic       m_done[4];
  logic       m_perr[4];
  logic       m_lock[4];
  logic [7:0] mb_cfg;
  logic       mb_done;
  logic       mb_lock;

  function automatic exp_t snap(input string name);
    exp_t e;
    e.name = name;
    for (int c = 0; c < 4; c++) begin
      e.cfg[c*8 +: 8] = m_cfg[c];
      e.done[c]       = m_done[c];
      e.perr[c]       = m_perr[c];
    end
    e.alld   = m_done[0] & m_done[1] & m_done[2] & m_done[3];
    e.cfg_b  = mb_cfg;
    e.done_b = mb_done;
    e.perr_b = 1'b0;
    return e;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < 4; c++) begin
      m_cfg[c] = 8'h00; m_done[c] = 1'b0; m_perr[c] = 1'b0; m_lock[c] = 1'b0;
    end
    mb_cfg = 8'h00; mb_done = 1'b0; mb_lock = 1'b0;
  endfunction

  // Even parity bit that makes the XOR of payload and parity zero.
  function automatic logic goodPar(input logic [7:0] p);
    return logic'($countones(p) % 2);
  endfunction

  function automatic logic frameBit(input logic [7:0] p, input int i, input logic par);
    if (i == 0) return 1'b1;
    if (i <= 8) return p[8 - i];
    return par;
  endfunction

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "cfg_o",        cfg,            e.cfg);
    cmp(e.name, "done_o",       32'(done),      32'(e.done));
    cmp(e.name, "perr_o",       32'(perr),      32'(e.perr));
    cmp(e.name, "all_done_o",   32'(alld),      32'(e.alld));
    cmp(e.name, "b.cfg_o",      32'(cfg_b),     32'(e.cfg_b));
    cmp(e.name, "b.done_o",     32'(done_b),    32'(e.done_b));
    cmp(e.name, "b.perr_o",     32'(perr_b),    32'(e.perr_b));
    cmp(e.name, "b.all_done_o", 32'(alld_b),    32'(e.done_b));
  endtask

  // Monitor: one expected snapshot is compared on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Sends one parity frame on every channel in mask at the same time.
  // rearm_last pulses re-arm on the parity-bit edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] data,
                               input logic [3:0] badpar, input logic [3:0] rearm_last,
                               input string name);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        logic [7:0] p;
        p = data[c*8 +: 8];
        ser[c] = mask[c] ? frameBit(p, i, goodPar(p) ^ badpar[c]) : 1'b0;
      end
      if (i == 9) begin
        rearm = rearm_last;
        exp_q.push_back(snap({name, "_pre"}));
      end
    end
    @(posedge clk); #1;
    ser   = 4'b0000;
    rearm = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (rearm_last[c]) begin
        m_done[c] = 1'b0; m_perr[c] = 1'b0; m_lock[c] = 1'b0;
      end else if (mask[c] && !m_lock[c]) begin
        if (!badpar[c]) begin
          m_cfg[c] = data[c*8 +: 8]; m_done[c] = 1'b1; m_perr[c] = 1'b0; m_lock[c] = 1'b1;
        end else begin
          m_done[c] = 1'b0; m_perr[c] = 1'b1;
        end
      end
    end
    exp_q.push_back(snap(name));
  endtask

  // Sends one parity-less frame to DUT B.
  task automatic applyStimulusB(input logic [7:0] p, input string name);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      ser_b[0] = frameBit(p, i, 1'b0);
      if (i == 8) exp_q.push_back(snap({name, "_pre"}));
    end
    @(posedge clk); #1;
    ser_b[0] = 1'b0;
    if (!mb_lock) begin
      mb_cfg = p; mb_done = 1'b1; mb_lock = 1'b1;
    end
    exp_q.push_back(snap(name));
  endtask

  task automatic rearmPulse(input logic [3:0] mask, input string name);
    @(posedge clk); #1;
    rearm = mask;
    @(posedge clk); #1;
    rearm = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        m_done[c] = 1'b0; m_perr[c] = 1'b0; m_lock[c] = 1'b0;
      end
    end
    exp_q.push_back(snap(name));
  endtask

  // Starts a frame on channel 3 and resets on the edge sampling payload bit 4.
  task automatic resetMidFrame(input logic [7:0] p, input string name);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ser[3] = frameBit(p, i, 1'b0);
      if (i == 4) rst = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    ser = 4'b0000;
    modelReset();
    exp_q.push_back(snap(name));
  endtask

  initial begin
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  bad;
    logic [3:0]  rl;

    rst     = 1'b0;
    ser     = 4'b0000;
    rearm   = 4'b0000;
    ser_b   = 1'b0;
    rearm_b = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(snap("reset"));
    @(posedge clk); #1;
    rst = 1'b1;

    applyStimulusB(8'hC3, "b_c3");
    applyStimulusB(8'h5A, "b_locked_ignore");

    applyStimulus(4'b0001, 32'h0000_00A5, 4'b0000, 4'b0000, "ch0_a5");
    applyStimulus(4'b0010, 32'h0000_0700, 4'b0010, 4'b0000, "ch1_badpar");
    applyStimulus(4'b1111, 32'hFF81_073C, 4'b0000, 4'b0000, "all_load");
    rearmPulse(4'b0100, "rearm_ch2");
    applyStimulus(4'b0100, 32'h0055_0000, 4'b0000, 4'b0100, "ch2_rearm_at_par");
    applyStimulus(4'b0100, 32'h0055_0000, 4'b0000, 4'b0000, "ch2_55");
    resetMidFrame(8'h12, "reset_mid_frame");
    applyStimulus(4'b1000, 32'h1200_0000, 4'b0000, 4'b0000, "ch3_12");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 3) begin
        rearmPulse(4'($urandom_range(0, 15)), $sformatf("rnd_rearm_%0d", it));
      end else begin
        mask = 4'($urandom_range(0, 15));
        data = $urandom;
        bad  = 4'($urandom & $urandom);
        rl   = 4'($urandom & $urandom & $urandom);
        applyStimulus(mask, data, bad, rl, $sformatf("rnd_frame_%0d", it));
      end
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cfg_serial_loader

// File: doc/cfg_serial_loader.md
CFG_SERIAL_LOADER -- requirements
Module: cfg_serial_loader

Interface
REQ-001 Parameter NCH, default 4: number of independent serial configuration channels.
REQ-002 Parameter W, default 8: payload width per channel, in bits (2..16).
REQ-003 Parameter PAR_EN, default 1: when 1, each frame carries one parity bit after the payload.
REQ-004 Parameter PAR_ODD, default 0: 0 selects even parity; 1 selects odd parity.
REQ-005 Port clk, input, 1 bit: single clock; all logic uses the rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port ser_i, input, NCH bits: serial data line per channel; idle level is low.
REQ-008 Port rearm_i, input, NCH bits: per-channel single-cycle re-arm request.
REQ-009 Port cfg_o, output, NCH*W bits: loaded word per channel; channel c occupies bits [c*W +: W].
REQ-010 Port done_o, output, NCH bits: channel holds a valid, parity-checked word.
REQ-011 Port perr_o, output, NCH bits: last frame on the channel failed the parity check.
REQ-012 Port all_done_o, output, 1 bit: AND of all done_o bits.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, SHIFT, PARITY and LOCKED.
REQ-014 IDLE: ser_i=1 sampled at edge k SHALL be taken as a start bit and move the FSM to SHIFT with the bit counter cleared.
REQ-015 SHIFT: payload bits are sampled MSB first at edges k+1..k+W into a working register.
- After the W-th bit, the FSM SHALL go to PARITY if PAR_EN=1, otherwise to LOCKED.
REQ-016 PARITY: the bit at edge k+W+1 is checked against the payload.
- Even parity: XOR of payload and parity bit equals 0.
- Odd parity: that XOR equals 1.
REQ-017 On frame completion (parity pass or PAR_EN=0), the working register SHALL be copied to that channel's cfg_o field, done_o SHALL be set and perr_o cleared, all at the same edge.
REQ-018 On parity fail, perr_o SHALL be set, done_o cleared and the cfg_o field left unchanged.
REQ-019 Latency: done_o/perr_o SHALL be visible in the cycle after edge k+W+1 (PAR_EN=1) or edge k+W (PAR_EN=0).
REQ-020 LOCKED SHALL ignore ser_i entirely; a following start bit SHALL NOT begin a new frame.
REQ-021 rearm_i=1 in any state SHALL return the FSM to IDLE at that edge.
- It clears done_o and perr_o.
- It retains cfg_o.
- It discards any partial frame.
REQ-022 If rearm_i and a frame-completing bit occur at the same edge, rearm SHALL win: no cfg_o update, done_o=0.
REQ-023 ser_i is not sampled for a start bit at the edge that re-arms the FSM; the earliest start bit is at the next edge.
REQ-024 all_done_o SHALL be combinational from the done_o register bits.
REQ-025 Channels SHALL NOT interact; a simultaneous start, completion or rearm on several channels is handled independently per channel.

Reset
REQ-026 rst=0 at a rising edge SHALL set every FSM to IDLE and clear cfg_o, done_o, perr_o and the bit counters, so all_done_o=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first start bit is accepted at the first edge with rst=1.

Structure
REQ-028 Shared package cfg_loader_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, PARITY, LOCKED) and the default parameter constants.
REQ-029 The per-channel FSM, counter and working register SHALL be sub-module cfg_ser_chan, instantiated NCH times by a generate loop.
REQ-030 The top level SHALL contain only the generate loop, the cfg_o packing and the all_done_o reduction.

Verification (NCH=4, W=8, PAR_EN=1, PAR_ODD=0)
REQ-031 Channel 0 sends start, 0xA5 MSB first, parity 0 -> cfg_o[7:0]=0xA5 and done_o[0]=1 at start-edge+10, perr_o[0]=0.
REQ-032 Channel 1 sends 0x07 with parity 0 (bad) -> perr_o[1]=1, done_o[1]=0, cfg_o[15:8] stays 0x00.
REQ-033 All channels load 0x3C/0x07/0x81/0xFF with correct parity on the same cycles -> all_done_o rises on one edge; the extra pulses sent to channel 0 while LOCKED leave 0xA5-style data unchanged.
REQ-034 rearm_i[2] at the parity-bit edge of a 0x55 frame -> done_o[2]=0 and cfg_o[23:16] keeps its old value; a next frame of 0x55 then loads normally.
REQ-035 rst=0 asserted at payload bit 4 of channel 3 -> all outputs 0; a full frame of 0x12 after release loads 0x12.
REQ-036 PAR_EN=0 build, 0xC3 frame -> done_o[0]=1 at start-edge+9 with no parity cycle.
